// File: rtl/fetch_branch_ctrl.sv
// Fetch/branch sequencer: walks fetch, decode and stage-0 hand-off, resolves
// branches, calls and returns, and takes interrupts through a small return stack.
module fetch_branch_ctrl #(
    parameter int AW    = 8,
    parameter int IW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [IW-1:0] instr,
    input  logic [AW-1:0] target,
    input  logic [3:0]    ccr,
    input  logic          i_pending,
    input  logic [AW-1:0] i_vector,
    input  logic          stg1_state,
    output logic          stg0_state,
    output logic [AW-1:0] pc_out,
    output logic          pc_load,
    output logic          ir_load,
    output logic          int_ack,
    output logic          stk_ovf,
    output logic          stk_unf,
    output logic [3:0]    state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [4:0] OP_BRA  = 5'b00110;
    localparam logic [4:0] OP_JMP  = 5'b00111;
    localparam logic [4:0] OP_BSR  = 5'b10101;
    localparam logic [4:0] OP_RTS  = 5'b01000;
    localparam logic [4:0] OP_RTI  = 5'b01001;
    localparam logic [4:0] OP_LMSK = 5'b01110;

    typedef enum logic [3:0] {
        S_RST = 4'd0, S_FETCH = 4'd1, S_INT_PUSH = 4'd2, S_INT_VEC = 4'd3,
        S_IR_LD = 4'd4, S_DECODE = 4'd5, S_HANDOFF = 4'd6, S_BR_HS = 4'd7,
        S_BR_EVAL = 4'd8, S_TAKE = 4'd9, S_CALL = 4'd10, S_RET = 4'd11,
        S_MASK = 4'd12
    } state_t;

    state_t          cur, nxt;
    logic            mask;
    logic [AW-1:0]   stk [DEPTH];
    logic [CW-1:0]   cnt, top;
    logic            full, empty, push, cond_ok;
    logic [4:0]      opcode;
    logic            unused_v;

    assign opcode   = instr[IW-1:IW-5];
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign top      = cnt - CW'(1);
    assign push     = (cur == S_INT_PUSH) || (cur == S_CALL);
    assign unused_v = ccr[0];

    // ccr is {N,Z,C,V}
    always_comb begin
        cond_ok = 1'b0;
        case (instr[2:0])
            3'b000: cond_ok = ccr[2];
            3'b001: cond_ok = !ccr[2];
            3'b010: cond_ok = ccr[1];
            3'b011: cond_ok = !ccr[1];
            3'b100: cond_ok = ccr[3];
            3'b101: cond_ok = !ccr[3];
            3'b110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_RST:      nxt = S_FETCH;
            S_FETCH:    nxt = (i_pending && !mask) ? S_INT_PUSH : S_IR_LD;
            S_INT_PUSH: nxt = S_INT_VEC;
            S_INT_VEC:  nxt = S_IR_LD;
            S_IR_LD:    nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_BRA:         nxt = S_BR_HS;
                    OP_JMP:         nxt = S_TAKE;
                    OP_BSR:         nxt = S_CALL;
                    OP_RTS, OP_RTI: nxt = S_RET;
                    OP_LMSK:        nxt = S_MASK;
                    default:        nxt = S_HANDOFF;
                endcase
            end
            S_HANDOFF:  nxt = stg1_state ? S_FETCH : S_HANDOFF;
            S_BR_HS:    nxt = stg1_state ? S_BR_EVAL : S_BR_HS;
            S_BR_EVAL:  nxt = cond_ok ? S_TAKE : S_FETCH;
            S_TAKE:     nxt = S_FETCH;
            S_CALL:     nxt = S_TAKE;
            S_RET:      nxt = S_FETCH;
            S_MASK:     nxt = S_FETCH;
            default:    nxt = S_FETCH;
        endcase
    end

    // Strobes are Moore decodes, forced low while clr is held
    assign state      = cur;
    assign stg0_state = !clr && ((cur == S_HANDOFF) || (cur == S_BR_HS));
    assign int_ack    = !clr && (cur == S_INT_PUSH);
    assign ir_load    = !clr && (cur == S_IR_LD);
    assign pc_load    = !clr && ((cur == S_INT_VEC) || (cur == S_TAKE) ||
                                 ((cur == S_RET) && !empty));

    always_ff @(posedge clk) begin
        if (clr) begin
            cur     <= S_RST;
            pc_out  <= '0;
            mask    <= 1'b0;
            cnt     <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            cur <= nxt;
            case (cur)
                S_INT_PUSH, S_CALL: begin
                    if (full) stk_ovf <= 1'b1;
                    else      cnt     <= cnt + CW'(1);
                end
                S_INT_VEC: begin
                    pc_out <= i_vector;
                    mask   <= 1'b1;
                end
                S_IR_LD: pc_out <= pc_out + AW'(1);
                S_TAKE:  pc_out <= target;
                S_RET: begin
                    if (empty) begin
                        stk_unf <= 1'b1;
                    end else begin
                        pc_out <= stk[top[PW-1:0]];
                        cnt    <= top;
                    end
                    if (opcode == OP_RTI) mask <= 1'b0;
                end
                S_MASK: mask <= instr[0];
                default: ;
            endcase
        end
    end

    // Stack storage needs no reset; occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (!clr && push && !full) stk[cnt[PW-1:0]] <= pc_out;
    end
endmodule

// File: doc/fetch_branch_ctrl.md
FETCH_BRANCH_CTRL -- requirements
Module: fetch_branch_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8: PC/address width.
REQ-002 SHALL have parameter IW, default 8: instruction width; opcode = instr[IW-1:IW-5], cond = instr[2:0].
REQ-003 SHALL have parameter DEPTH, default 4: return-address stack entries, power of two, >=2.
REQ-004 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port clr  in  1  reset; synchronous and active-high.
REQ-006 SHALL have port instr  in  IW  contents of instruction register.
REQ-007 SHALL have port target  in  AW  jump/branch destination operand.
REQ-008 SHALL have port ccr  in  4  condition codes {N,Z,C,V}, bit3 = N.
REQ-009 SHALL have port i_pending  in  1  pending interrupt request.
REQ-010 SHALL have port i_vector  in  AW  interrupt service address.
REQ-011 SHALL have port stg1_state  in  1  stage-1 ready/acknowledge.
REQ-012 SHALL have port stg0_state  out  1  stage-0 hand-off request.
REQ-013 SHALL have port pc_out  out  AW  program counter.
REQ-014 SHALL have ports pc_load, ir_load, int_ack  out  1 each  one-cycle strobes.
REQ-015 SHALL have ports stk_ovf, stk_unf  out  1 each  sticky stack error flags.
REQ-016 SHALL have port state  out  4  encoded current state, for debug.

Function
REQ-017 SHALL implement states RST=0, FETCH=1, INT_PUSH=2, INT_VEC=3, IR_LD=4, DECODE=5, HANDOFF=6, BR_HS=7, BR_EVAL=8, TAKE=9, CALL=10, RET=11, MASK=12; codes 13-15 SHALL go to FETCH.
REQ-018 RST SHALL go to FETCH on the first clock with clr=0.
REQ-019 FETCH SHALL go to INT_PUSH if i_pending=1 and the internal mask=0, else to IR_LD.
REQ-020 INT_PUSH SHALL push pc_out, assert int_ack, and go to INT_VEC.
REQ-021 INT_VEC SHALL load pc_out<=i_vector, assert pc_load, set mask=1, and go to IR_LD.
REQ-022 IR_LD SHALL assert ir_load, increment pc_out modulo 2^AW (all-ones wraps to 0), and go to DECODE.
REQ-023 DECODE SHALL use opcodes BRA=00110, JMP=00111, BSR=10101, RTS=01000, RTI=01001, LMSK=01110; next state SHALL be BR_HS, TAKE, CALL, RET, RET, MASK respectively, otherwise HANDOFF.
REQ-024 In HANDOFF and BR_HS, stg0_state SHALL be 1 (Moore output); while stg1_state=0 the FSM SHALL hold.
REQ-025 When stg1_state=1 is sampled, HANDOFF SHALL go to FETCH and BR_HS SHALL go to BR_EVAL; stg0_state SHALL be 0 in the following state.
REQ-026 BR_EVAL SHALL evaluate cond as follows: 000 Z, 001 !Z, 010 C, 011 !C, 100 N, 101 !N, 110 always, 111 never. True SHALL go to TAKE; false SHALL go to FETCH with pc_out unchanged.
REQ-027 TAKE SHALL load pc_out<=target, assert pc_load, and go to FETCH.
REQ-028 CALL SHALL push the already-incremented pc_out, then go to TAKE.
REQ-029 RET SHALL pop the top entry into pc_out, assert pc_load, and go to FETCH; for RTI it SHALL also clear mask.
REQ-030 MASK SHALL set mask<=instr[0] and go to FETCH.
REQ-031 The stack SHALL be LIFO with an occupancy count of 0..DEPTH.
REQ-032 Push when full SHALL drop the push, set stk_ovf, and leave the flow unchanged.
REQ-033 Pop when empty SHALL set stk_unf, suppress pc_load, leave pc_out unchanged, and still go to FETCH.
REQ-034 stk_ovf and stk_unf SHALL clear only on clr.
REQ-035 Strobes SHALL be high exactly one cycle, only in the stated states.
REQ-036 i_pending SHALL be sampled only in FETCH; assertions in other states SHALL be ignored until the next FETCH.

Reset
REQ-037 While clr=1, state SHALL be RST, pc_out=0, all strobes 0, stg0_state=0, mask=0, stack count=0, and stk_ovf=stk_unf=0.
REQ-038 clr asserted in any state, including mid-handshake, SHALL take effect at the next clock edge and abandon the operation in progress.

Verification
REQ-039 SHALL test reset then an ALU opcode with stg1_state tied to 1: states 1,4,5,6,1; pc_out 0->1; stg0_state high one cycle.
REQ-040 SHALL test BRA cond=000 with Z=1 and target=0x40: pc_out=0x40 with pc_load after BR_EVAL; repeat with Z=0: pc_out stays at the incremented value.
REQ-041 SHALL test the handshake with stg1_state held 0 for 5 cycles: FSM held in HANDOFF, stg0_state=1 for 6 cycles.
REQ-042 SHALL test i_pending=1, mask=0, pc=0x10, i_vector=0xF0: int_ack, 0x10 pushed, pc_out=0xF0; a following RTI restores 0x10 and clears mask.
REQ-043 SHALL test DEPTH+1 nested BSR: stk_ovf=1 on the last call; DEPTH+2 RTS: stk_unf=1 and pc_out unchanged on the final RTS.
REQ-044 SHALL test pc_out=0xFF (AW=8) in IR_LD: pc_out wraps to 0x00; clr pulsed during BR_HS: RST with pc_out=0.
